echo_delay_scheduler: RTL and testbench

//  Sequences all accesses to the shared single-port echo delay memory, one stereo frame at a time.

---
 rtl/echo_delay_scheduler_if.sv | 44 ++++
 rtl/echo_delay_scheduler.sv | 118 +++++++++++
 tb/tb_echo_delay_scheduler.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/echo_delay_scheduler_if.sv
// Frame input, mixer output and delay-memory bus of the echo delay scheduler.
// master = surrounding system, slave = scheduler.
interface echo_delay_scheduler_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14
);
  logic                  i_valid;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] i_left;
  logic [DATA_WIDTH-1:0] i_right;
  logic [ADDR_WIDTH-2:0] i_delay;
  logic                  o_valid;
  logic                  o_ready;
  logic [DATA_WIDTH-1:0] o_dry_left;
  logic [DATA_WIDTH-1:0] o_dry_right;
  logic [DATA_WIDTH-1:0] o_wet_left;
  logic [DATA_WIDTH-1:0] o_wet_right;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  modport master (
    output i_valid, i_left, i_right, i_delay,
    input  i_ready,
    input  o_valid, o_dry_left, o_dry_right,
    input  o_wet_left, o_wet_right,
    output o_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

  modport slave (
    input  i_valid, i_left, i_right, i_delay,
    output i_ready,
    output o_valid, o_dry_left, o_dry_right,
    output o_wet_left, o_wet_right,
    input  o_ready,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );
endinterface

// File: rtl/echo_delay_scheduler.sv
// Echo delay scheduler: one stereo frame at a time, reads the delayed
// pair, writes the new pair, then hands dry/wet pairs to the mixer.
module echo_delay_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14
) (
  input logic clk,
  input logic reset,
  echo_delay_scheduler_if.slave bus
);
  localparam int FW = ADDR_WIDTH - 1;
  localparam logic [FW-1:0] ONE = 1;
  localparam logic [FW-1:0] FULL = '1;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD_L = 3'd1;
  localparam logic [2:0] RD_R = 3'd2;
  localparam logic [2:0] WR_L = 3'd3;
  localparam logic [2:0] WR_R = 3'd4;
  localparam logic [2:0] OUT  = 3'd5;

  logic [2:0]            state;
  logic [FW-1:0]         wp;
  logic [FW-1:0]         fill;
  logic [FW-1:0]         d;
  logic [FW-1:0]         rp;
  logic                  wet_ok;
  logic [DATA_WIDTH-1:0] dry_l;
  logic [DATA_WIDTH-1:0] dry_r;
  logic [DATA_WIDTH-1:0] wet_l;
  logic [DATA_WIDTH-1:0] wet_r;
  logic                  accept;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] rd_val;

  assign rp = wp - d;
  assign bus.i_ready = (state == IDLE) & ~reset;
  assign accept = bus.i_valid & bus.i_ready;
  assign bus.mem_req = (state == RD_L) | (state == RD_R) |
                       (state == WR_L) | (state == WR_R);
  assign xfer = bus.mem_req & bus.mem_ack;
  assign rd_val = wet_ok ? bus.mem_rdata : '0;

  assign bus.o_valid     = (state == OUT);
  assign bus.o_dry_left  = dry_l;
  assign bus.o_dry_right = dry_r;
  assign bus.o_wet_left  = wet_l;
  assign bus.o_wet_right = wet_r;

  // Memory command decoded from state; held constant while stalled.
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (1'b1)
      (state == RD_L): bus.mem_addr = {rp, 1'b0};
      (state == RD_R): bus.mem_addr = {rp, 1'b1};
      (state == WR_L): begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = {wp, 1'b0};
        bus.mem_wdata = dry_l;
      end
      (state == WR_R): begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = {wp, 1'b1};
        bus.mem_wdata = dry_r;
      end
      default: ;
    endcase
  end

  // Frame sequencer, pointers and latched frame data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      wp     <= '0;
      fill   <= '0;
      d      <= '0;
      wet_ok <= 1'b0;
      dry_l  <= '0;
      dry_r  <= '0;
      wet_l  <= '0;
      wet_r  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          dry_l  <= bus.i_left;
          dry_r  <= bus.i_right;
          d      <= bus.i_delay;
          wet_ok <= fill >= bus.i_delay;
          if (bus.i_delay == '0) begin
            wet_l <= bus.i_left;
            wet_r <= bus.i_right;
            state <= WR_L;
          end else begin
            state <= RD_L;
          end
        end
        RD_L: if (xfer) begin
          wet_l <= rd_val;
          state <= RD_R;
        end
        RD_R: if (xfer) begin
          wet_r <= rd_val;
          state <= WR_L;
        end
        WR_L: if (xfer) state <= WR_R;
        WR_R: if (xfer) begin
          wp    <= wp + ONE;
          if (fill != FULL) fill <= fill + ONE;
          state <= OUT;
        end
        OUT: if (bus.o_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_echo_delay_scheduler.sv
// Testbench for echo_delay_scheduler: 8-frame buffer, memory model
// with programmable ack delay, table vectors plus corner sequences.
module tb_echo_delay_scheduler;
  localparam int DW = 32;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  echo_delay_scheduler_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifc ();

  echo_delay_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk),
    .reset(reset),
    .bus(ifc)
  );

  int total = 0;
  int bad = 0;

  logic [DW-1:0] mem [16];
  int ack_wait = 0;
  int wcnt = 0;
  int stall_bad = 0;
  int xfers = 0;
  int wrs = 0;
  logic [AW-1:0] waddr_q [$];
  logic [AW-1:0] p_addr;
  logic          p_we;
  logic [DW-1:0] p_wdata;

  assign ifc.mem_ack = ifc.mem_req && (wcnt >= ack_wait);
  assign ifc.mem_rdata = ifc.mem_req ? mem[ifc.mem_addr] : '0;

  // memory model: stall counter, write port, transfer log
  always @(posedge clk) begin
    if (ifc.mem_req) begin
      if (wcnt > 0 && (ifc.mem_addr != p_addr || ifc.mem_we != p_we ||
                       ifc.mem_wdata != p_wdata))
        stall_bad <= stall_bad + 1;
      p_addr  <= ifc.mem_addr;
      p_we    <= ifc.mem_we;
      p_wdata <= ifc.mem_wdata;
    end
    if (ifc.mem_req && ifc.mem_ack) begin
      xfers <= xfers + 1;
      wcnt  <= 0;
      if (ifc.mem_we) begin
        mem[ifc.mem_addr] <= ifc.mem_wdata;
        wrs <= wrs + 1;
        waddr_q.push_back(ifc.mem_addr);
      end
    end else if (ifc.mem_req) begin
      wcnt <= wcnt + 1;
    end else begin
      wcnt <= 0;
    end
  end

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    logic [AW-2:0] d;
    logic [DW-1:0] wl;
    logic [DW-1:0] wr;
    int            lat;
    int            xf;
  } vec_t;

  vec_t tbl [4];

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    logic [7:0] z;
    @(negedge clk);
    reset = 1'b1;
    ifc.i_valid = 1'b0;
    ifc.o_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    z = {ifc.o_valid, ifc.mem_req, ifc.mem_we, ifc.i_ready,
         |ifc.mem_addr, |ifc.mem_wdata,
         |{ifc.o_dry_left, ifc.o_dry_right},
         |{ifc.o_wet_left, ifc.o_wet_right}};
    check("reset_outputs_zero", {24'b0, z}, 0);
    reset = 1'b0;
    #1;
    check("i_ready_after_reset", {31'b0, ifc.i_ready}, 1);
    waddr_q.delete();
  endtask

  task automatic run_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                           input logic [AW-2:0] d, input int hold,
                           output logic [DW-1:0] dl, output logic [DW-1:0] dr,
                           output logic [DW-1:0] wl, output logic [DW-1:0] wr,
                           output int lat, output int held_bad);
    int n;
    held_bad = 0;
    lat = 0;
    ifc.o_ready = (hold == 0);
    @(negedge clk);
    ifc.i_valid = 1'b1;
    ifc.i_left  = l;
    ifc.i_right = r;
    ifc.i_delay = d;
    n = 0;
    while (!ifc.i_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("i_ready_wait", {31'b0, ifc.i_ready}, 1);
    @(posedge clk);
    #1;
    ifc.i_valid = 1'b0;
    ifc.i_delay = ~d;
    ifc.i_left  = ~l;
    ifc.i_right = ~r;
    do begin
      @(negedge clk);
      lat++;
    end while (!ifc.o_valid && lat < 100);
    check("o_valid_seen", {31'b0, ifc.o_valid}, 1);
    dl = ifc.o_dry_left;
    dr = ifc.o_dry_right;
    wl = ifc.o_wet_left;
    wr = ifc.o_wet_right;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (!ifc.o_valid || ifc.i_ready || ifc.o_dry_left !== dl ||
          ifc.o_dry_right !== dr || ifc.o_wet_left !== wl ||
          ifc.o_wet_right !== wr)
        held_bad++;
    end
    ifc.o_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] dl, dr, wl, wr;
    int lat, hb, x0, w0, s0, seq_bad;

    for (int i = 0; i < 16; i++) mem[i] = '0;
    ifc.i_valid = 1'b0;
    ifc.i_left  = '0;
    ifc.i_right = '0;
    ifc.i_delay = '0;
    ifc.o_ready = 1'b1;

    tbl[0] = '{32'h1,  32'h100, 3'd2, 32'h0,  32'h0,   5, 4};
    tbl[1] = '{32'h2,  32'h200, 3'd2, 32'h0,  32'h0,   5, 4};
    tbl[2] = '{32'h3,  32'h300, 3'd2, 32'h1,  32'h100, 5, 4};
    tbl[3] = '{32'hAA, 32'hBB,  3'd0, 32'hAA, 32'hBB,  3, 2};

    do_reset();

    for (int i = 0; i < 4; i++) begin
      x0 = xfers;
      w0 = wrs;
      run_frame(tbl[i].l, tbl[i].r, tbl[i].d, 0, dl, dr, wl, wr, lat, hb);
      check($sformatf("v%0d_dry_l", i), dl, tbl[i].l);
      check($sformatf("v%0d_dry_r", i), dr, tbl[i].r);
      check($sformatf("v%0d_wet_l", i), wl, tbl[i].wl);
      check($sformatf("v%0d_wet_r", i), wr, tbl[i].wr);
      check($sformatf("v%0d_latency", i), lat, tbl[i].lat);
      check($sformatf("v%0d_xfers", i), xfers - x0, tbl[i].xf);
      check($sformatf("v%0d_writes", i), wrs - w0, 2);
    end

    do_reset();
    for (int n = 0; n < 20; n++) begin
      run_frame(n, n + 32'h1000, 3'd7, 0, dl, dr, wl, wr, lat, hb);
      check($sformatf("wrap%0d_wet_l", n), wl, (n >= 7) ? n - 7 : 0);
      check($sformatf("wrap%0d_wet_r", n), wr,
            (n >= 7) ? n - 7 + 32'h1000 : 0);
    end
    seq_bad = 0;
    for (int i = 0; i < 40; i++)
      if (i >= waddr_q.size() || waddr_q[i] != 4'(i)) seq_bad++;
    check("wrap_write_count", waddr_q.size(), 40);
    check("wrap_addr_sequence", seq_bad, 0);

    do_reset();
    ack_wait = 3;
    s0 = stall_bad;
    for (int i = 0; i < 3; i++) begin
      run_frame(tbl[i].l, tbl[i].r, tbl[i].d, 0, dl, dr, wl, wr, lat, hb);
      check($sformatf("slow%0d_dry_l", i), dl, tbl[i].l);
      check($sformatf("slow%0d_wet_l", i), wl, tbl[i].wl);
      check($sformatf("slow%0d_wet_r", i), wr, tbl[i].wr);
      check($sformatf("slow%0d_latency", i), lat, 17);
    end
    check("slow_stall_stable", stall_bad - s0, 0);
    ack_wait = 0;

    do_reset();
    run_frame(32'h55, 32'h66, 3'd0, 5, dl, dr, wl, wr, lat, hb);
    check("hold_outputs_stable", hb, 0);
    check("hold_wet_l", wl, 32'h55);
    check("hold_wet_r", wr, 32'h66);
    check("hold_latency", lat, 3);

    @(negedge clk);
    ifc.i_valid = 1'b1;
    ifc.i_left  = 32'h77;
    ifc.i_right = 32'h88;
    ifc.i_delay = 3'd1;
    @(posedge clk);
    #1;
    ifc.i_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_in_rd_r", {29'b0, ifc.mem_req, ifc.mem_we, ifc.mem_addr[0]},
          3'b101);
    reset = 1'b1;
    #1;
    check("mid_rst_mem_req", {31'b0, ifc.mem_req}, 0);
    check("mid_rst_o_valid", {31'b0, ifc.o_valid}, 0);
    do_reset();
    run_frame(32'h99, 32'hAA, 3'd0, 0, dl, dr, wl, wr, lat, hb);
    check("after_rst_writes", waddr_q.size(), 2);
    check("after_rst_addr0", (waddr_q.size() > 0) ? waddr_q[0] : 4'hF, 0);
    check("after_rst_addr1", (waddr_q.size() > 1) ? waddr_q[1] : 4'hF, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
